// File: rtl/our_ack_process.sv
// TX-side peer-ACK tracker for a single TCP flow: advances snd_una / TX buffer head,
// tracks the peer window, counts duplicate ACKs and raises retransmit requests.
//
// state    | meaning
// IDLE     | flow not opened, ACKs not accepted
// OPEN     | normal operation, ACKs accepted, RTO timer armed while data outstanding
// RT_REQ   | retransmit request presented to send engine, ACKs stalled
// RECOVERY | retransmit issued, waiting for a new ACK (or another timeout)
module our_ack_process #(
  parameter int unsigned SEQ_W      = 32,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned TX_PTR_W   = 14,
  parameter int unsigned DUP_THRESH = 3,
  parameter int unsigned RTO_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_val,
  input  logic [SEQ_W-1:0]    init_snd_una,
  input  logic [SEQ_W-1:0]    tx_snd_nxt,
  input  logic                ack_in_val,
  output logic                ack_in_rdy,
  input  logic [SEQ_W-1:0]    ack_in_num,
  input  logic [WIN_W-1:0]    ack_in_win,
  input  logic                ack_in_has_pyld,
  output logic [SEQ_W-1:0]    snd_una,
  output logic [TX_PTR_W:0]   tx_head_ptr,
  output logic [WIN_W-1:0]    snd_wnd,
  output logic [WIN_W:0]      usable_win,
  output logic                rt_req_val,
  input  logic                rt_req_rdy,
  output logic [SEQ_W-1:0]    rt_req_seq,
  output logic                rt_req_cause
);

  localparam int unsigned TMR_W = $clog2(RTO_CYCLES + 1);
  localparam int unsigned DC_W  = $clog2(DUP_THRESH + 1);
  localparam int unsigned UW    = WIN_W + 1;

  typedef enum logic [1:0] {IDLE, OPEN, RT_REQ, RECOVERY} state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [DC_W-1:0]   dup_cnt;
  logic [SEQ_W-1:0]  adv, out, wnd_ext;
  logic              ack_fire, ack_new, ack_zero, ack_dup, ack_upd, dup_hit;
  logic              tmr_run, expire, cause_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = 1'b0;
    adv       = ack_in_num - snd_una;
    out       = tx_snd_nxt - snd_una;
    ack_fire  = ack_in_val && ack_in_rdy && !init_val;
    ack_new   = ack_fire && (adv != '0) && (adv <= out);
    ack_zero  = ack_fire && (adv == '0);
    ack_dup   = ack_zero && (out != '0) && !ack_in_has_pyld && (ack_in_win == snd_wnd);
    ack_upd   = ack_zero && !ack_dup;
    dup_hit   = ack_dup && (dup_cnt == DC_W'(DUP_THRESH - 1));
    tmr_run   = ((state == OPEN) || (state == RECOVERY)) && (out != '0);
    // a new ACK in the same cycle restarts the timer instead of letting it expire
    expire    = tmr_run && !ack_new && (timer == TMR_W'(RTO_CYCLES - 1));
    unique case (state)
      IDLE: state_nxt = IDLE;
      OPEN: begin
        if (dup_hit) begin
          state_nxt = RT_REQ;
          cause_nxt = 1'b0;
        end else if (expire) begin
          state_nxt = RT_REQ;
          cause_nxt = 1'b1;
        end
      end
      RT_REQ: if (rt_req_rdy) state_nxt = RECOVERY;
      RECOVERY: begin
        if (ack_new) begin
          state_nxt = OPEN;
        end else if (expire) begin
          state_nxt = RT_REQ;
          cause_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (init_val) state_nxt = OPEN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_una      <= '0;
      tx_head_ptr  <= '0;
      snd_wnd      <= '0;
      dup_cnt      <= '0;
      timer        <= '0;
      rt_req_cause <= 1'b0;
    end else if (init_val) begin
      snd_una      <= init_snd_una;
      tx_head_ptr  <= '0;
      snd_wnd      <= '0;
      dup_cnt      <= '0;
      timer        <= '0;
      rt_req_cause <= 1'b0;
    end else begin
      if (ack_new) begin
        snd_una     <= ack_in_num;
        tx_head_ptr <= tx_head_ptr + adv[TX_PTR_W:0];
        snd_wnd     <= ack_in_win;
        dup_cnt     <= '0;
      end else if (ack_dup) begin
        if (dup_cnt != DC_W'(DUP_THRESH)) dup_cnt <= dup_cnt + 1'b1;
      end else if (ack_upd) begin
        snd_wnd <= ack_in_win;
      end
      // timer is held at zero throughout RT_REQ and resumes from zero after the handshake
      if ((state == RT_REQ) || (state_nxt == RT_REQ)) timer <= '0;
      else if (ack_new)                               timer <= '0;
      else if (tmr_run)                               timer <= timer + 1'b1;
      else                                            timer <= '0;
      if ((state != RT_REQ) && (state_nxt == RT_REQ)) rt_req_cause <= cause_nxt;
    end
  end

  assign ack_in_rdy = (state == OPEN) || (state == RECOVERY);
  assign rt_req_val = (state == RT_REQ);
  assign rt_req_seq = snd_una;

  assign wnd_ext    = {{(SEQ_W - WIN_W){1'b0}}, snd_wnd};
  assign usable_win = (out > wnd_ext) ? '0 : UW'(wnd_ext - out);

endmodule

// File: tb/tb_our_ack_process.sv
// Directed bench for our_ack_process with a short retransmit timeout (100 cycles).
module tb_our_ack_process;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_val;
  logic [31:0] init_snd_una;
  logic [31:0] tx_snd_nxt;
  logic        ack_in_val;
  logic        ack_in_rdy;
  logic [31:0] ack_in_num;
  logic [15:0] ack_in_win;
  logic        ack_in_has_pyld;
  logic [31:0] snd_una;
  logic [14:0] tx_head_ptr;
  logic [15:0] snd_wnd;
  logic [16:0] usable_win;
  logic        rt_req_val;
  logic        rt_req_rdy;
  logic [31:0] rt_req_seq;
  logic        rt_req_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  our_ack_process #(.RTO_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .init_val(init_val), .init_snd_una(init_snd_una),
    .tx_snd_nxt(tx_snd_nxt), .ack_in_val(ack_in_val), .ack_in_rdy(ack_in_rdy),
    .ack_in_num(ack_in_num), .ack_in_win(ack_in_win), .ack_in_has_pyld(ack_in_has_pyld),
    .snd_una(snd_una), .tx_head_ptr(tx_head_ptr), .snd_wnd(snd_wnd),
    .usable_win(usable_win), .rt_req_val(rt_req_val), .rt_req_rdy(rt_req_rdy),
    .rt_req_seq(rt_req_seq), .rt_req_cause(rt_req_cause)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_init(input logic [31:0] una, input logic [31:0] nxt);
    init_val     = 1'b1;
    init_snd_una = una;
    tx_snd_nxt   = nxt;
    tick();
    init_val = 1'b0;
  endtask

  task automatic send_ack(input logic [31:0] num, input logic [15:0] win, input logic pyld);
    ack_in_val      = 1'b1;
    ack_in_num      = num;
    ack_in_win      = win;
    ack_in_has_pyld = pyld;
    tick();
    ack_in_val = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++; if (ack_in_rdy !== 1'b0)   begin n_fail++; $display("FAIL reset_rdy got %0b want 0", ack_in_rdy); end
    n_checks++; if (rt_req_val !== 1'b0)   begin n_fail++; $display("FAIL reset_rtval got %0b want 0", rt_req_val); end
    n_checks++; if (snd_una !== 32'd0)     begin n_fail++; $display("FAIL reset_una got %0h want 0", snd_una); end
    n_checks++; if (tx_head_ptr !== 15'd0) begin n_fail++; $display("FAIL reset_head got %0h want 0", tx_head_ptr); end
    n_checks++; if (usable_win !== 17'd0)  begin n_fail++; $display("FAIL reset_usable got %0d want 0", usable_win); end
    rst = 1'b0;
    tick();
    n_checks++; if (ack_in_rdy !== 1'b0)   begin n_fail++; $display("FAIL idle_rdy got %0b want 0", ack_in_rdy); end
  endtask

  task automatic test_new_ack;
    do_init(32'd1000, 32'd1300);
    n_checks++; if (ack_in_rdy !== 1'b1)   begin n_fail++; $display("FAIL open_rdy got %0b want 1", ack_in_rdy); end
    n_checks++; if (snd_una !== 32'd1000)  begin n_fail++; $display("FAIL init_una got %0d want 1000", snd_una); end
    n_checks++; if (usable_win !== 17'd0)  begin n_fail++; $display("FAIL init_usable got %0d want 0", usable_win); end
    send_ack(32'd1100, 16'd4096, 1'b0);
    n_checks++; if (snd_una !== 32'd1100)    begin n_fail++; $display("FAIL new_una got %0d want 1100", snd_una); end
    n_checks++; if (tx_head_ptr !== 15'd100) begin n_fail++; $display("FAIL new_head got %0d want 100", tx_head_ptr); end
    n_checks++; if (snd_wnd !== 16'd4096)    begin n_fail++; $display("FAIL new_wnd got %0d want 4096", snd_wnd); end
    n_checks++; if (usable_win !== 17'd3896) begin n_fail++; $display("FAIL new_usable got %0d want 3896", usable_win); end
  endtask

  task automatic test_dup_ack;
    send_ack(32'd1100, 16'd4096, 1'b0);
    send_ack(32'd1100, 16'd4096, 1'b0);
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL dup2_rtval got %0b want 0", rt_req_val); end
    send_ack(32'd1100, 16'd4096, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rt_req_val !== 1'b1)     begin n_fail++; $display("FAIL dup_rtval[%0d] got %0b want 1", i, rt_req_val); end
      n_checks++; if (rt_req_seq !== 32'd1100) begin n_fail++; $display("FAIL dup_seq[%0d] got %0d want 1100", i, rt_req_seq); end
      n_checks++; if (rt_req_cause !== 1'b0)   begin n_fail++; $display("FAIL dup_cause[%0d] got %0b want 0", i, rt_req_cause); end
      n_checks++; if (ack_in_rdy !== 1'b0)     begin n_fail++; $display("FAIL rtreq_rdy[%0d] got %0b want 0", i, ack_in_rdy); end
      tick();
    end
    rt_req_rdy = 1'b1;
    tick();
    rt_req_rdy = 1'b0;
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL recov_rtval got %0b want 0", rt_req_val); end
    n_checks++; if (ack_in_rdy !== 1'b1) begin n_fail++; $display("FAIL recov_rdy got %0b want 1", ack_in_rdy); end
    send_ack(32'd1100, 16'd4096, 1'b0);
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL recov_dup_rtval got %0b want 0", rt_req_val); end
    send_ack(32'd1300, 16'd4096, 1'b0);
    n_checks++; if (snd_una !== 32'd1300)     begin n_fail++; $display("FAIL full_una got %0d want 1300", snd_una); end
    n_checks++; if (tx_head_ptr !== 15'd300)  begin n_fail++; $display("FAIL full_head got %0d want 300", tx_head_ptr); end
    n_checks++; if (usable_win !== 17'd4096)  begin n_fail++; $display("FAIL full_usable got %0d want 4096", usable_win); end
    tick(150);
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL timer_stopped got %0b want 0", rt_req_val); end
    n_checks++; if (ack_in_rdy !== 1'b1) begin n_fail++; $display("FAIL open_again_rdy got %0b want 1", ack_in_rdy); end
  endtask

  task automatic test_wrap;
    do_init(32'hFFFF_FFF0, 32'h0000_0010);
    send_ack(32'h0000_0008, 16'd100, 1'b0);
    n_checks++; if (snd_una !== 32'h8)       begin n_fail++; $display("FAIL wrap_una got %0h want 8", snd_una); end
    n_checks++; if (tx_head_ptr !== 15'h18)  begin n_fail++; $display("FAIL wrap_head got %0h want 18", tx_head_ptr); end
    n_checks++; if (usable_win !== 17'd92)   begin n_fail++; $display("FAIL wrap_usable got %0d want 92", usable_win); end
  endtask

  task automatic test_ignored;
    send_ack(32'h0000_0011, 16'd555, 1'b0);
    send_ack(32'h0000_0007, 16'd555, 1'b0);
    n_checks++; if (snd_una !== 32'h8)      begin n_fail++; $display("FAIL ign_una got %0h want 8", snd_una); end
    n_checks++; if (tx_head_ptr !== 15'h18) begin n_fail++; $display("FAIL ign_head got %0h want 18", tx_head_ptr); end
    n_checks++; if (snd_wnd !== 16'd100)    begin n_fail++; $display("FAIL ign_wnd got %0d want 100", snd_wnd); end
    n_checks++; if (usable_win !== 17'd92)  begin n_fail++; $display("FAIL ign_usable got %0d want 92", usable_win); end
    n_checks++; if (rt_req_val !== 1'b0)    begin n_fail++; $display("FAIL ign_rtval got %0b want 0", rt_req_val); end
    send_ack(32'h0000_0008, 16'd200, 1'b1);
    n_checks++; if (snd_wnd !== 16'd200)    begin n_fail++; $display("FAIL winupd_wnd got %0d want 200", snd_wnd); end
  endtask

  task automatic test_timeout;
    do_init(32'd5000, 32'd5010);
    tick(99);
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL rto_early got %0b want 0", rt_req_val); end
    tick();
    n_checks++; if (rt_req_val !== 1'b1)     begin n_fail++; $display("FAIL rto_val got %0b want 1", rt_req_val); end
    n_checks++; if (rt_req_cause !== 1'b1)   begin n_fail++; $display("FAIL rto_cause got %0b want 1", rt_req_cause); end
    n_checks++; if (rt_req_seq !== 32'd5000) begin n_fail++; $display("FAIL rto_seq got %0d want 5000", rt_req_seq); end
    rt_req_rdy = 1'b1;
    tick();
    rt_req_rdy = 1'b0;
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL rto_drop got %0b want 0", rt_req_val); end
    tick(99);
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL rto2_early got %0b want 0", rt_req_val); end
    tick();
    n_checks++; if (rt_req_val !== 1'b1)   begin n_fail++; $display("FAIL rto2_val got %0b want 1", rt_req_val); end
    n_checks++; if (rt_req_cause !== 1'b1) begin n_fail++; $display("FAIL rto2_cause got %0b want 1", rt_req_cause); end
  endtask

  task automatic test_dup_timeout_tie;
    do_init(32'd7000, 32'd7010);
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL tie_init_rtval got %0b want 0", rt_req_val); end
    ack_in_val      = 1'b1;
    ack_in_num      = 32'd7000;
    ack_in_win      = 16'd0;
    ack_in_has_pyld = 1'b0;
    tick(2);
    ack_in_val = 1'b0;
    tick(97);
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL tie_early got %0b want 0", rt_req_val); end
    send_ack(32'd7000, 16'd0, 1'b0);
    n_checks++; if (rt_req_val !== 1'b1)   begin n_fail++; $display("FAIL tie_val got %0b want 1", rt_req_val); end
    n_checks++; if (rt_req_cause !== 1'b0) begin n_fail++; $display("FAIL tie_cause got %0b want 0", rt_req_cause); end
  endtask

  task automatic test_reset_mid;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rt_req_val !== 1'b0)   begin n_fail++; $display("FAIL rstmid_rtval got %0b want 0", rt_req_val); end
    n_checks++; if (ack_in_rdy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_rdy got %0b want 0", ack_in_rdy); end
    n_checks++; if (snd_una !== 32'd0)     begin n_fail++; $display("FAIL rstmid_una got %0d want 0", snd_una); end
    n_checks++; if (rt_req_seq !== 32'd0)  begin n_fail++; $display("FAIL rstmid_seq got %0d want 0", rt_req_seq); end
    n_checks++; if (usable_win !== 17'd0)  begin n_fail++; $display("FAIL rstmid_usable got %0d want 0", usable_win); end
    tick();
    rst = 1'b0;
    tick(2);
    n_checks++; if (ack_in_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_rdy got %0b want 0", ack_in_rdy); end
    n_checks++; if (rt_req_val !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_rtval got %0b want 0", rt_req_val); end
  endtask

  initial begin
    rst             = 1'b1;
    init_val        = 1'b0;
    init_snd_una    = '0;
    tx_snd_nxt      = '0;
    ack_in_val      = 1'b0;
    ack_in_num      = '0;
    ack_in_win      = '0;
    ack_in_has_pyld = 1'b0;
    rt_req_rdy      = 1'b0;
    test_reset();
    test_new_ack();
    test_dup_ack();
    test_wrap();
    test_ignored();
    test_timeout();
    test_dup_timeout_tie();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
